// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage RV32I core: memory freeze, MDU hold,
// taken-branch flush and multi-bubble load-use interlock, plus stall/flush counters.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              mdu_start,
  input  logic              mdu_done,
  input  logic              mem_wait,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_sel,
  output logic              ex_mem_sel,
  output logic              ex_mem_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned LU_W = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;

  typedef enum logic [2:0] {
    RUN,
    LOAD_USE,
    FLUSH,
    MDU_HOLD,
    FREEZE
  } mode_t;

  logic [LU_W-1:0] luCnt;
  logic            mduBusy;
  logic            luHazard;
  logic            mduHold;
  mode_t           mode;

  // A load in EX whose destination feeds the ID instruction; x0 never counts.
  assign luHazard = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  // The mdu_done cycle is not a hold: the result moves on into EX/MEM.
  assign mduHold = mdu_start || (mduBusy && !mdu_done);

  // Mode decode, highest priority first.
  always_comb begin
    mode = RUN;
    if (mem_wait)                          mode = FREEZE;
    else if (mduHold)                      mode = MDU_HOLD;
    else if (ex_branch_taken)              mode = FLUSH;
    else if (luHazard || (luCnt != '0))    mode = LOAD_USE;
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_sel    = 1'b0;
    ex_mem_sel   = 1'b0;
    ex_mem_write = 1'b1;
    unique case (mode)
      FREEZE: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
      end
      MDU_HOLD: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
        ex_mem_sel  = 1'b1;
      end
      FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_sel   = 1'b1;
      end
      LOAD_USE: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_sel   = 1'b1;
      end
      default: ;
    endcase
  end

  // Squashing the dependent instruction on a flush also cancels its pending bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luCnt     <= '0;
      mduBusy   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mode != FREEZE) begin
        if (mdu_start)     mduBusy <= 1'b1;
        else if (mdu_done) mduBusy <= 1'b0;

        if (mode == FLUSH)            luCnt <= '0;
        else if (luCnt != '0)         luCnt <= luCnt - LU_W'(1);
        else if (mode == LOAD_USE)    luCnt <= LU_W'(LOAD_STALL - 1);
      end
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((mode == FLUSH) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances (LOAD_STALL 1/3/2, the last with
// 4-bit counters) share one stimulus bus; each scenario resets and checks one instance.
module tb_hazard_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic       mdu_start, mdu_done, mem_wait;

  // Control word: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_sel, ex_mem_sel, ex_mem_write}
  localparam logic [6:0] C_RUN    = 7'b1101001;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_MDU    = 7'b0000011;
  localparam logic [6:0] C_FLUSH  = 7'b1111101;
  localparam logic [6:0] C_LU     = 7'b0001101;

  logic        pcA, ifwA, iffA, iewA, iesA, emsA, emwA;
  logic        pcB, ifwB, iffB, iewB, iesB, emsB, emwB;
  logic        pcC, ifwC, iffC, iewC, iesC, emsC, emwC;
  logic [15:0] stallA, flushA, stallB, flushB;
  logic [3:0]  stallC, flushC;
  logic [6:0]  ctlA, ctlB, ctlC;

  assign ctlA = {pcA, ifwA, iffA, iewA, iesA, emsA, emwA};
  assign ctlB = {pcB, ifwB, iffB, iewB, iesB, emsB, emwB};
  assign ctlC = {pcC, ifwC, iffC, iewC, iesC, emsC, emwC};

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mdu_start(mdu_start),
    .mdu_done(mdu_done), .mem_wait(mem_wait), .pc_write(pcA), .if_id_write(ifwA),
    .if_id_flush(iffA), .id_ex_write(iewA), .id_ex_sel(iesA), .ex_mem_sel(emsA),
    .ex_mem_write(emwA), .stall_cnt(stallA), .flush_cnt(flushA));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(16)) dutB (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mdu_start(mdu_start),
    .mdu_done(mdu_done), .mem_wait(mem_wait), .pc_write(pcB), .if_id_write(ifwB),
    .if_id_flush(iffB), .id_ex_write(iewB), .id_ex_sel(iesB), .ex_mem_sel(emsB),
    .ex_mem_write(emwB), .stall_cnt(stallB), .flush_cnt(flushB));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(2), .CNT_W(4)) dutC (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .mdu_start(mdu_start),
    .mdu_done(mdu_done), .mem_wait(mem_wait), .pc_write(pcC), .if_id_write(ifwC),
    .if_id_flush(iffC), .id_ex_write(iewC), .id_ex_sel(iesC), .ex_mem_sel(emsC),
    .ex_mem_write(emwC), .stall_cnt(stallC), .flush_cnt(flushC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearIn();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0; mem_wait = 1'b0;
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic doReset();
    clearIn();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic loadUse(input logic [4:0] rd, input logic [4:0] rs);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rs; id_use_rs1 = 1'b1;
  endtask

  initial begin
    clearIn();
    rst_n = 1'b0;
    #12;
    mid();
    expectEq("reset_ctl", 32'(ctlA), 32'(C_RUN));
    expectEq("reset_stall", 32'(stallA), 32'd0);
    expectEq("reset_flush", 32'(flushA), 32'd0);
    rst_n = 1'b1;
    tick();

    // LOAD_STALL=1: one bubble
    loadUse(5'd2, 5'd2);
    mid(); expectEq("ls1_bubble", 32'(ctlA), 32'(C_LU));
    tick(); clearIn();
    mid(); expectEq("ls1_resume", 32'(ctlA), 32'(C_RUN));
    expectEq("ls1_stall_cnt", 32'(stallA), 32'd1);

    // rs2 path, and rs1 match with use flag low
    doReset();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    mid(); expectEq("ls1_rs2_bubble", 32'(ctlA), 32'(C_LU));
    tick(); clearIn();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
    mid(); expectEq("ls1_unused_rs1", 32'(ctlA), 32'(C_RUN));
    tick(); clearIn();

    // LOAD_STALL=3: three bubbles, then x0 never stalls
    doReset();
    loadUse(5'd2, 5'd2);
    mid(); expectEq("ls3_b0", 32'(ctlB), 32'(C_LU));
    tick(); clearIn();
    mid(); expectEq("ls3_b1", 32'(ctlB), 32'(C_LU));
    tick();
    mid(); expectEq("ls3_b2", 32'(ctlB), 32'(C_LU));
    tick();
    mid(); expectEq("ls3_resume", 32'(ctlB), 32'(C_RUN));
    expectEq("ls3_stall_cnt", 32'(stallB), 32'd3);
    loadUse(5'd0, 5'd0);
    mid(); expectEq("ls3_x0", 32'(ctlB), 32'(C_RUN));
    tick(); clearIn();
    mid(); expectEq("ls3_x0_next", 32'(ctlB), 32'(C_RUN));
    expectEq("ls3_x0_stall_cnt", 32'(stallB), 32'd3);

    // MDU: start at cycle 0, done at cycle 5
    doReset();
    mdu_start = 1'b1;
    mid(); expectEq("mdu_c0", 32'(ctlA), 32'(C_MDU));
    tick(); clearIn();
    for (int c = 1; c <= 4; c++) begin
      mid(); expectEq($sformatf("mdu_c%0d", c), 32'(ctlA), 32'(C_MDU));
      tick();
    end
    mdu_done = 1'b1;
    mid(); expectEq("mdu_done_cycle", 32'(ctlA), 32'(C_RUN));
    tick(); clearIn();
    mid(); expectEq("mdu_after", 32'(ctlA), 32'(C_RUN));
    expectEq("mdu_stall_cnt", 32'(stallA), 32'd5);

    // Branch flush cancels a same-cycle load-use hazard (LOAD_STALL=2)
    doReset();
    loadUse(5'd2, 5'd2);
    ex_branch_taken = 1'b1;
    mid(); expectEq("flush_ctl", 32'(ctlC), 32'(C_FLUSH));
    tick(); clearIn();
    mid(); expectEq("flush_no_bubble", 32'(ctlC), 32'(C_RUN));
    expectEq("flush_cnt", 32'(flushC), 32'd1);
    expectEq("flush_stall_cnt", 32'(stallC), 32'd0);

    // Freeze during a pending bubble: bubble survives the freeze
    doReset();
    loadUse(5'd3, 5'd3);
    mid(); expectEq("frz_first_bubble", 32'(ctlC), 32'(C_LU));
    tick(); clearIn();
    mem_wait = 1'b1;
    mid(); expectEq("frz_c0", 32'(ctlC), 32'(C_FREEZE));
    tick();
    mid(); expectEq("frz_c1", 32'(ctlC), 32'(C_FREEZE));
    tick(); clearIn();
    mid(); expectEq("frz_remaining_bubble", 32'(ctlC), 32'(C_LU));
    tick();
    mid(); expectEq("frz_resume", 32'(ctlC), 32'(C_RUN));
    expectEq("frz_stall_cnt", 32'(stallC), 32'd4);

    // 4-bit counters saturate
    doReset();
    mem_wait = 1'b1;
    repeat (15) tick();
    mid(); expectEq("sat_stall_15", 32'(stallC), 32'd15);
    repeat (5) tick();
    mid(); expectEq("sat_stall_20", 32'(stallC), 32'd15);
    clearIn();
    ex_branch_taken = 1'b1;
    repeat (20) tick();
    mid(); expectEq("sat_flush_20", 32'(flushC), 32'd15);
    tick(); clearIn();

    // Reset in the middle of an MDU hold
    mdu_start = 1'b1;
    tick(); clearIn();
    mid(); expectEq("rst_mdu_held", 32'(ctlC), 32'(C_MDU));
    rst_n = 1'b0;
    #1;
    expectEq("rst_mdu_ctl", 32'(ctlC), 32'(C_RUN));
    expectEq("rst_mdu_stall", 32'(stallC), 32'd0);
    expectEq("rst_mdu_flush", 32'(flushC), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    mid(); expectEq("rst_mdu_after", 32'(ctlC), 32'(C_RUN));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
